// File: rtl/cc_rst_seq.sv
// ---------------------------------------------------------------------------
// cc_rst_seq
//
// Soft-reset sequencer for a core complex. When syscfg requests a soft reset,
// the sequencer gates new AXI address requests from the core, waits for all
// outstanding reads and writes to complete (bounded by a timeout), holds the
// core in reset for a fixed number of cycles, then latches the boot address
// and releases the core. This keeps the core from being reset while it still
// has transactions in flight on the crossbar.
//
// Parameters:
//   HOLD_CYCLES     cycles core_rst_no stays low in RESET (>= 1)
//   TIMEOUT_CYCLES  maximum cycles spent draining (>= 1)
//   MAX_OUTST       maximum outstanding transactions per direction
//
// Ports:
//   clk_i           core clock
//   rst_ni          synchronous active-low reset
//   soft_rst_req_i  level soft-reset request from syscfg
//   boot_addr_i     boot address from syscfg
//   aw_fire_i       AW handshake on the core master port
//   ar_fire_i       AR handshake on the core master port
//   b_fire_i        B handshake on the core master port
//   r_last_fire_i   last-beat R handshake on the core master port
//   axi_gate_o      1: force the core's AW/AR valid low
//   core_rst_no     core soft reset, active-low
//   boot_addr_o     latched boot address presented to the core
//   busy_o          sequencer is not in RUN
//   timeout_o       sticky: last drain ended by timeout
//   err_o           sticky: an outstanding counter over/underflowed
// ---------------------------------------------------------------------------
module cc_rst_seq #(
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_OUTST      = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        soft_rst_req_i,
    input  logic [31:0] boot_addr_i,
    input  logic        aw_fire_i,
    input  logic        ar_fire_i,
    input  logic        b_fire_i,
    input  logic        r_last_fire_i,
    output logic        axi_gate_o,
    output logic        core_rst_no,
    output logic [31:0] boot_addr_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic        err_o
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTST);
    localparam logic [HW-1:0] HOLD_END = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_RESET    = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic          timeout_reg, timeout_next;
    logic          err_reg;
    logic          gate_reg;
    logic          rst_n_reg;
    logic          busy_reg;
    logic [31:0]   boot_addr_reg;

    // ------------------------------------------------------------------
    // Outstanding counters, index 0 = write (AW/B), index 1 = read (AR/R).
    // ------------------------------------------------------------------
    logic [1:0]         cnt_inc;
    logic [1:0]         cnt_dec;
    logic [1:0][CW-1:0] cnt_reg;
    logic [1:0][CW-1:0] cnt_next;
    logic [1:0]         cnt_err;
    logic               cnt_clear;
    logic               cnt_idle;

    assign cnt_inc = {ar_fire_i, aw_fire_i};
    assign cnt_dec = {r_last_fire_i, b_fire_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic up_only;
            logic dn_only;
            logic ovf;
            logic unf;

            // A request and a response in the same cycle cancel out and can
            // never over/underflow, even at the counter limits.
            assign up_only = cnt_inc[gi] & ~cnt_dec[gi];
            assign dn_only = cnt_dec[gi] & ~cnt_inc[gi];
            assign ovf     = up_only & (cnt_reg[gi] == CNT_MAX);
            assign unf     = dn_only & (cnt_reg[gi] == '0);

            assign cnt_err[gi]  = ovf | unf;
            assign cnt_next[gi] = (up_only && !ovf) ? cnt_reg[gi] + CW'(1) :
                                  (dn_only && !unf) ? cnt_reg[gi] - CW'(1) :
                                                      cnt_reg[gi];
        end
    endgenerate

    assign cnt_idle = (cnt_reg[0] == '0) && (cnt_reg[1] == '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        to_cnt_next   = to_cnt_reg;
        timeout_next  = timeout_reg;

        case (state_reg)
            ST_RUN: begin
                if (soft_rst_req_i) begin
                    state_next  = ST_DRAIN;
                    to_cnt_next = '0;
                end
            end
            ST_DRAIN: begin
                // Request deassertion is ignored here: once draining starts
                // the sequence always completes. Completion beats timeout.
                if (cnt_idle) begin
                    state_next    = ST_RESET;
                    hold_cnt_next = '0;
                    timeout_next  = 1'b0;
                end else if (to_cnt_reg == TO_END) begin
                    state_next    = ST_RESET;
                    hold_cnt_next = '0;
                    timeout_next  = 1'b1;
                end else begin
                    to_cnt_next = to_cnt_reg + TW'(1);
                end
            end
            ST_RESET: begin
                if (hold_cnt_reg == HOLD_END) begin
                    hold_cnt_next = '0;
                    state_next    = soft_rst_req_i ? ST_WAIT_REL : ST_RUN;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HW'(1);
                end
            end
            ST_WAIT_REL: begin
                if (!soft_rst_req_i) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RESET;
            end
        endcase
    end

    // Pending core transactions are discarded when the core goes into reset.
    assign cnt_clear = (state_reg == ST_DRAIN) && (state_next == ST_RESET);

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg     <= ST_RESET;
            hold_cnt_reg  <= '0;
            to_cnt_reg    <= '0;
            cnt_reg       <= '0;
            timeout_reg   <= 1'b0;
            err_reg       <= 1'b0;
            gate_reg      <= 1'b1;
            rst_n_reg     <= 1'b0;
            busy_reg      <= 1'b1;
            boot_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            to_cnt_reg   <= to_cnt_next;
            timeout_reg  <= timeout_next;
            err_reg      <= err_reg | (|cnt_err);
            cnt_reg      <= cnt_clear ? '0 : cnt_next;

            // Outputs are decoded from the next state so they change on the
            // same edge as the state register.
            gate_reg  <= (state_next != ST_RUN);
            busy_reg  <= (state_next != ST_RUN);
            rst_n_reg <= (state_next == ST_RUN) || (state_next == ST_DRAIN);

            // Track the boot address while the core is held; the final load
            // happens on the release edge, so it is stable from then on.
            if ((state_reg == ST_RESET) || (state_reg == ST_WAIT_REL)) begin
                boot_addr_reg <= boot_addr_i;
            end
        end
    end

    assign axi_gate_o  = gate_reg;
    assign core_rst_no = rst_n_reg;
    assign busy_o      = busy_reg;
    assign boot_addr_o = boot_addr_reg;
    assign timeout_o   = timeout_reg;
    assign err_o       = err_reg;

endmodule

// File: tb/tb_cc_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_cc_rst_seq
//
// Directed bench for cc_rst_seq. Two instances share all inputs: dut_a uses
// the default drain timeout, dut_b uses an 8-cycle timeout for the timeout
// scenarios. Expected values are queued when stimulus is applied and popped
// when the corresponding output is sampled (1 time unit after the clock edge).
// ---------------------------------------------------------------------------
module tb_cc_rst_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] boot_addr;
    logic        aw, ar, b, rl;

    logic        a_gate, a_rst_no, a_busy, a_timeout, a_err;
    logic [31:0] a_boot;
    logic        b_gate, b_rst_no, b_busy, b_timeout, b_err;
    logic [31:0] b_boot;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    cc_rst_seq #(.HOLD_CYCLES(16), .TIMEOUT_CYCLES(1024), .MAX_OUTST(15)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .soft_rst_req_i(req), .boot_addr_i(boot_addr),
        .aw_fire_i(aw), .ar_fire_i(ar), .b_fire_i(b), .r_last_fire_i(rl),
        .axi_gate_o(a_gate), .core_rst_no(a_rst_no), .boot_addr_o(a_boot),
        .busy_o(a_busy), .timeout_o(a_timeout), .err_o(a_err)
    );

    cc_rst_seq #(.HOLD_CYCLES(16), .TIMEOUT_CYCLES(8), .MAX_OUTST(15)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .soft_rst_req_i(req), .boot_addr_i(boot_addr),
        .aw_fire_i(aw), .ar_fire_i(ar), .b_fire_i(b), .r_last_fire_i(rl),
        .axi_gate_o(b_gate), .core_rst_no(b_rst_no), .boot_addr_o(b_boot),
        .busy_o(b_busy), .timeout_o(b_timeout), .err_o(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        sb_q.push_back('{tag, v});
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Count edges until the selected instance releases core_rst_no (bounded).
    task automatic wait_rel(input bit sel, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (((sel ? b_rst_no : a_rst_no) !== 1'b1) && (n < 200));
    endtask

    int n;

    initial begin
        rst_n = 1'b0; req = 1'b0; boot_addr = 32'h8000_0000;
        aw = 1'b0; ar = 1'b0; b = 1'b0; rl = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick(); tick();
        expect_val("rst_gate", 32'd1);    check(32'(a_gate));
        expect_val("rst_rst_no", 32'd0);  check(32'(a_rst_no));
        expect_val("rst_busy", 32'd1);    check(32'(a_busy));
        expect_val("rst_boot", 32'd0);    check(a_boot);
        expect_val("rst_timeout", 32'd0); check(32'(a_timeout));
        expect_val("rst_err", 32'd0);     check(32'(a_err));

        // ---------------- power-on ----------------
        rst_n = 1'b1;
        expect_val("por_hold_cycles", 32'd16);
        wait_rel(1'b0, n); check(32'(n));
        expect_val("por_gate", 32'd0);         check(32'(a_gate));
        expect_val("por_busy", 32'd0);         check(32'(a_busy));
        expect_val("por_boot", 32'h8000_0000); check(a_boot);
        $display("[TB] power-on: release after %0d cycles, boot=%h", n, a_boot);

        // ---------------- drain ----------------
        aw = 1'b1; ar = 1'b1; tick();
        tick();
        ar = 1'b0; tick();
        aw = 1'b0;
        req = 1'b1; tick();              // edge N: request sampled in RUN
        req = 1'b0;
        expect_val("drain_gate", 32'd1);   check(32'(a_gate));
        expect_val("drain_busy", 32'd1);   check(32'(a_busy));
        expect_val("drain_rst_no", 32'd1); check(32'(a_rst_no));
        for (int k = 1; k <= 10; k++) begin
            b  = (k >= 5) && (k <= 7);
            rl = (k >= 9);
            tick();
        end
        b = 1'b0; rl = 1'b0;
        expect_val("drain_not_yet_reset", 32'd1); check(32'(a_rst_no));
        tick();
        expect_val("drain_reset_entry", 32'd0); check(32'(a_rst_no));
        expect_val("drain_timeout", 32'd0);     check(32'(a_timeout));
        expect_val("drain_hold_cycles", 32'd16);
        wait_rel(1'b0, n); check(32'(n));
        expect_val("drain_gate_after", 32'd0);  check(32'(a_gate));
        $display("[TB] drain: hold %0d cycles, timeout=%0b", n, a_timeout);

        // ---------------- timeout (dut_b, 8 cycles) ----------------
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        wait_rel(1'b1, n);
        aw = 1'b1; tick(); aw = 1'b0;
        req = 1'b1; tick(); req = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while ((b_rst_no !== 1'b0) && (n < 100));
        expect_val("to_drain_cycles", 32'd8);  check(32'(n));
        expect_val("to_timeout_flag", 32'd1);  check(32'(b_timeout));
        expect_val("to_a_still_drain", 32'd1); check(32'(a_rst_no));
        expect_val("to_hold_cycles", 32'd16);
        wait_rel(1'b1, n); check(32'(n));
        // Counters were cleared on RESET entry: the next drain is immediate.
        req = 1'b1; tick(); req = 1'b0;
        tick();
        expect_val("to_cnt_cleared", 32'd0);     check(32'(b_rst_no));
        expect_val("to_flag_cleared", 32'd0);    check(32'(b_timeout));
        $display("[TB] timeout: drain lasted 8 cycles, flag cleared on clean drain");

        // ---------------- held request ----------------
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        wait_rel(1'b0, n);
        req = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k == 25) boot_addr = 32'h0000_1000;
            tick();
            if (k == 20) begin
                expect_val("held_past_hold", 32'd0); check(32'(a_rst_no));
            end
            if (k == 25) begin
                expect_val("held_boot_track", 32'h0000_1000); check(a_boot);
            end
        end
        expect_val("held_last_req_edge", 32'd0); check(32'(a_rst_no));
        req = 1'b0; tick();
        expect_val("held_release", 32'd1);      check(32'(a_rst_no));
        expect_val("held_gate", 32'd0);         check(32'(a_gate));
        expect_val("held_boot", 32'h0000_1000); check(a_boot);
        $display("[TB] held request: released one edge after deassertion, boot=%h", a_boot);

        // ---------------- simultaneous events and errors ----------------
        aw = 1'b1; tick();               // wr_cnt = 1
        b = 1'b1; tick();                // AW+B together: stays 1
        aw = 1'b0; b = 1'b0;
        expect_val("sim_no_err", 32'd0); check(32'(a_err));
        req = 1'b1; tick(); req = 1'b0;
        tick(); tick(); tick();
        expect_val("sim_still_drain", 32'd1); check(32'(a_rst_no));
        b = 1'b1; tick(); b = 1'b0;      // wr_cnt -> 0
        tick();
        expect_val("sim_one_outstanding", 32'd0); check(32'(a_rst_no));
        wait_rel(1'b0, n);
        b = 1'b1; tick(); b = 1'b0;      // underflow at 0
        expect_val("unf_err", 32'd1); check(32'(a_err));
        req = 1'b1; tick(); req = 1'b0;
        tick();
        expect_val("unf_cnt_zero", 32'd0); check(32'(a_rst_no));
        wait_rel(1'b0, n);
        $display("[TB] simultaneous/underflow: err=%0b", a_err);

        // ---------------- overflow ----------------
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        expect_val("ovf_err_cleared", 32'd0); check(32'(a_err));
        wait_rel(1'b0, n);
        ar = 1'b1;
        repeat (15) tick();
        expect_val("ovf_at_max_no_err", 32'd0); check(32'(a_err));
        tick(); ar = 1'b0;
        expect_val("ovf_err", 32'd1); check(32'(a_err));
        $display("[TB] overflow: err=%0b", a_err);

        // ---------------- reset mid-DRAIN ----------------
        req = 1'b1; tick(); req = 1'b0;
        repeat (10) tick();
        expect_val("mid_a_drain", 32'd1);   check(32'(a_rst_no));
        expect_val("mid_b_timeout", 32'd1); check(32'(b_timeout));
        rst_n = 1'b0; tick();
        expect_val("mid_rst_no", 32'd0);     check(32'(a_rst_no));
        expect_val("mid_gate", 32'd1);       check(32'(a_gate));
        expect_val("mid_err_clr", 32'd0);    check(32'(a_err));
        expect_val("mid_b_to_clr", 32'd0);   check(32'(b_timeout));
        rst_n = 1'b1;
        expect_val("mid_hold_cycles", 32'd16);
        wait_rel(1'b0, n); check(32'(n));
        req = 1'b1; tick(); req = 1'b0;
        tick();
        expect_val("mid_cnt_cleared", 32'd0); check(32'(a_rst_no));
        $display("[TB] reset mid-drain: hold %0d cycles", n);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
